// File: rtl/instruction_sequencer.sv
// Control sequencer for an 8-bit accumulator machine: fetch/decode/execute FSM, PC and IR.
// Optional build macro SINGLE_STEP_EN adds a Step input that gates each instruction fetch.
module instruction_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enter,
`ifdef SINGLE_STEP_EN
  input  logic       Step,
`endif
  input  logic [7:0] RAM_output,
  input  logic       Aeq0,
  input  logic       Apos,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       MemWr,
  output logic [4:0] RAMAddress,
  output logic [4:0] PC,
  output logic [7:0] IR,
  output logic       Halt
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_INWAIT  = 3'd4,
    S_INREL   = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  // Memory-operand instructions need an extra address-setup cycle before EXEC.
  function automatic state_t dispatch_state(input logic [2:0] op);
    case (op)
      OP_LOAD, OP_ADD, OP_SUB:   dispatch_state = S_OPERAND;
      OP_STORE, OP_JZ, OP_JPOS:  dispatch_state = S_EXEC;
      OP_INPUT:                  dispatch_state = S_INWAIT;
      OP_HALT:                   dispatch_state = S_HALT;
      default:                   dispatch_state = S_HALT;
    endcase
  endfunction

  function automatic logic jump_taken(input logic [2:0] op, input logic zero_flag,
                                      input logic pos_flag);
    case (op)
      OP_JZ:   jump_taken = zero_flag;
      OP_JPOS: jump_taken = pos_flag;
      default: jump_taken = 1'b0;
    endcase
  endfunction

  state_t     state_r;
  state_t     state_s;
  logic [4:0] pc_r;
  logic [4:0] pc_s;
  logic [7:0] ir_r;
  logic [7:0] ir_s;
  logic [2:0] op_s;

  assign op_s = ir_r[7:5];
  assign PC   = pc_r;
  assign IR   = ir_r;

  // State, program counter and instruction register; reset aborts any instruction in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_FETCH;
      pc_r    <= 5'd0;
      ir_r    <= 8'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
    end
  end

  // Next-state, PC and IR update logic.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    case (state_r)
      S_FETCH: begin
`ifdef SINGLE_STEP_EN
        if (Step) begin
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
`else
        state_s = S_DECODE;
`endif
      end
      S_DECODE: begin
        ir_s    = RAM_output;
        pc_s    = pc_r + 5'd1;
        state_s = dispatch_state(RAM_output[7:5]);
      end
      S_OPERAND: begin
        state_s = S_EXEC;
      end
      S_EXEC: begin
        state_s = S_FETCH;
        // A taken jump replaces the increment already applied in DECODE.
        if (jump_taken(op_s, Aeq0, Apos)) begin
          pc_s = ir_r[4:0];
        end else begin
          pc_s = pc_r;
        end
      end
      S_INWAIT: begin
        if (Enter) begin
          state_s = S_INREL;
        end else begin
          state_s = S_INWAIT;
        end
      end
      S_INREL: begin
        if (!Enter) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_INREL;
        end
      end
      S_HALT: begin
        state_s = S_HALT;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // Datapath controls decoded from state and IR; load and write strobes are mutually exclusive.
  always_comb begin
    Aload      = 1'b0;
    MemWr      = 1'b0;
    Sub        = 1'b0;
    Asel       = ASEL_ALU;
    RAMAddress = pc_r;
    Halt       = 1'b0;
    case (state_r)
      S_OPERAND: begin
        RAMAddress = ir_r[4:0];
      end
      S_EXEC: begin
        RAMAddress = ir_r[4:0];
        case (op_s)
          OP_LOAD: begin
            Aload = 1'b1;
            Asel  = ASEL_RAM;
          end
          OP_ADD: begin
            Aload = 1'b1;
            Asel  = ASEL_ALU;
          end
          OP_SUB: begin
            Aload = 1'b1;
            Asel  = ASEL_ALU;
            Sub   = 1'b1;
          end
          OP_STORE: begin
            MemWr = 1'b1;
          end
          default: begin
            Aload = 1'b0;
            MemWr = 1'b0;
          end
        endcase
      end
      S_INWAIT: begin
        // Only the cycle that leaves INWAIT loads; INREL absorbs a held Enter.
        if (Enter) begin
          Aload = 1'b1;
          Asel  = ASEL_IN;
        end else begin
          Aload = 1'b0;
          Asel  = ASEL_ALU;
        end
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      default: begin
        Halt = 1'b0;
      end
    endcase
  end

endmodule
